// File: rtl/lsu_mem_ctrl.sv
`timescale 1ns/1ps
// lsu_mem_ctrl: load/store unit between the decoder's S/L-type accesses and
// a word-wide synchronous data RAM (byte enables, 1-cycle read latency).
// Build option LSU_MISALIGN_SPLIT_EN: misaligned H/W accesses are executed
// (split into two RAM accesses when they cross a word) instead of erroring.
module lsu_mem_ctrl #(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_ISSUE2, S_WAIT2, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [2:0]        type_q;
    logic [1:0]        off_q;
    logic [MEM_AW-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic              split_q;
    logic [63:0]       rdata_q;   // {second word, first word} as read back

    logic              accept;
    logic              req_legal;
    logic              req_err;
    logic              req_split;
    logic [1:0]        req_off;
    logic              unused_addr_hi;

    assign accept         = (state_q == S_IDLE) && req_valid;
    assign req_off        = req_addr[1:0];
    // Upper address bits alias onto the RAM and are deliberately dropped.
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

    // Classify the incoming request: legal func3, alignment, word crossing.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        req_split = 1'b0;
        req_legal = req_we ? (req_type inside {3'b000, 3'b001, 3'b010})
                           : (req_type inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_SPLIT_EN
        req_err   = !req_legal;
        req_split = req_legal && (((req_type[1:0] == 2'b01) && (req_off == 2'b11)) ||
                                  ((req_type[1:0] == 2'b10) && (req_off != 2'b00)));
`else
        req_err   = !req_legal ||
                    ((req_type[1:0] == 2'b01) && req_off[0]) ||
                    ((req_type[1:0] == 2'b10) && (req_off != 2'b00));
`endif
    end

`ifndef LSU_MISALIGN_SPLIT_EN
    assign split_q = 1'b0;
`endif

    // Capture request fields at the accept edge; collect read data per access.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            we_q    <= 1'b0;
            type_q  <= 3'b000;
            off_q   <= 2'b00;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= 1'b0;
`endif
        end else if (accept) begin
            we_q    <= req_we;
            type_q  <= req_type;
            off_q   <= req_off;
            waddr_q <= req_addr[MEM_AW+1:2];
            wdata_q <= req_wdata;
            err_q   <= req_err;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q <= req_split;
`endif
        end else if (state_q == S_WAIT) begin
            rdata_q[31:0] <= mem_rdata;
        end else if (state_q == S_WAIT2) begin
            rdata_q[63:32] <= mem_rdata;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state sequencing: errors skip straight to the response cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = req_err ? S_DONE : S_ISSUE;
            S_ISSUE:  state_d = we_q ? (split_q ? S_ISSUE2 : S_DONE) : S_WAIT;
            S_WAIT:   state_d = split_q ? S_ISSUE2 : S_DONE;
            S_ISSUE2: state_d = we_q ? S_DONE : S_WAIT2;
            S_WAIT2:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    logic [3:0]  size_mask;
    logic [3:0]  be_lo;
    logic [31:0] lane_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [3:0]  be_hi;
    logic [31:0] wdata_src;
`endif

    // Byte-lane enables and lane-positioned store data for the captured access.
    always_comb begin
        case (type_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        case (type_q[1:0])
            2'b00:   lane_wdata = {4{wdata_q[7:0]}};
            2'b01:   lane_wdata = {2{wdata_q[15:0]}};
            default: lane_wdata = wdata_q;
        endcase
`ifdef LSU_MISALIGN_SPLIT_EN
        {be_hi, be_lo} = {4'b0000, size_mask} << off_q;
        // Misaligned data is rotated so byte k lands in lane (k+o) mod 4,
        // which is right for both halves of a split access.
        wdata_src = (type_q[1:0] == 2'b01) ? {16'h0000, wdata_q[15:0]} : wdata_q;
        if (((type_q[1:0] == 2'b01) && off_q[0]) ||
            ((type_q[1:0] == 2'b10) && (off_q != 2'b00)))
            lane_wdata = 32'({wdata_src, wdata_src} >> (6'd32 - {1'b0, off_q, 3'b000}));
`else
        be_lo = size_mask << off_q;
`endif
    end

    logic [31:0] ld_shift;
    logic [31:0] ld_ext;

    // RAM strobes, handshake and response outputs decoded from the state.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_be    = be_lo;
                mem_addr  = waddr_q;
                mem_wdata = we_q ? lane_wdata : 32'h0;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_ISSUE2: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_be    = be_hi;
                mem_addr  = waddr_q + MEM_AW'(1);
                mem_wdata = we_q ? lane_wdata : 32'h0;
            end
`endif
            default: ;
        endcase

        // Little-endian concatenation of the read words, then extension.
        ld_shift = 32'(rdata_q >> {off_q, 3'b000});
        case (type_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
        rsp_valid = (state_q == S_DONE);
        rsp_err   = (state_q == S_DONE) && err_q;
        rsp_rdata = ((state_q == S_DONE) && !err_q && !we_q) ? ld_ext : 32'h0;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
`timescale 1ns/1ps
// tb_lsu_mem_ctrl: directed and randomized checks of lsu_mem_ctrl against a
// byte-addressed reference memory; the bench also plays the data RAM.
module tb_lsu_mem_ctrl;

    localparam int MEM_AW = 8;
    localparam int DEPTH  = 2**MEM_AW;
    localparam int NBYTES = 4*DEPTH;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_we;
    logic [2:0]        req_type;
    logic [31:0]       req_addr, req_wdata;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic              mem_en, mem_we;
    logic [3:0]        mem_be;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    lsu_mem_ctrl #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word RAM with byte enables and one cycle of read latency.
    bit [31:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Reference model: flat byte memory, updated only by accepted stores.
    bit [7:0] ref_mem [0:NBYTES-1];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] t);
        case (t[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int base_idx(input logic [31:0] a);
        return int'(a[MEM_AW+1:0]);
    endfunction

    function automatic bit exp_err(input bit we, input logic [2:0] t, input logic [31:0] a);
        bit legal;
        legal = we ? (t <= 3'd2) : (t inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        if (SPLIT)  return 1'b0;
        return (int'(a[1:0]) % acc_size(t)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a);
        logic [31:0] v = '0;
        for (int i = 0; i < acc_size(t); i++)
            v[8*i +: 8] = ref_mem[(base_idx(a) + i) % NBYTES];
        if (t == 3'b000 && v[7])  v[31:8]  = '1;
        if (t == 3'b001 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    // Observations of the most recent transaction.
    int                n_stb;
    logic [MEM_AW-1:0] stb_addr [4];
    logic [3:0]        stb_be   [4];
    logic [31:0]       stb_wd   [4];
    logic              stb_we   [4];
    int                last_lat;
    logic [31:0]       last_rdata;
    logic              last_err;

    // Present one request, then watch strobes and the response cycle by cycle.
    // With hold set, req_valid stays high and the fields churn while busy.
    task automatic do_req(input bit we, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold);
        bit got = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = wd;
        check("ready_before_req", req_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) begin
            req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        end
        n_stb = 0; last_lat = 0; last_rdata = '0; last_err = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (mem_en) begin
                if (n_stb < 4) begin
                    stb_addr[n_stb] = mem_addr; stb_be[n_stb] = mem_be;
                    stb_wd[n_stb] = mem_wdata;  stb_we[n_stb] = mem_we;
                end
                n_stb++;
            end
            if (rsp_valid) begin
                got = 1'b1; last_lat = c; last_rdata = rsp_rdata; last_err = rsp_err;
            end else if (hold) begin
                req_valid = 1'b1; req_we = 1'b1; req_type = 3'($urandom_range(0, 2));
                req_addr = $urandom; req_wdata = $urandom;
            end
        end
        req_valid = 1'b0;
        check("rsp_seen", got, 1);
        @(negedge clk);
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_rsp_rdata", rsp_rdata, 0);
        check("idle_rsp_err", rsp_err, 0);
        check("idle_mem_en", mem_en, 0);
    endtask

    // Predict everything about one transaction from the access rules, run it, compare.
    task automatic run_and_check(input bit we, input logic [2:0] t, input logic [31:0] a,
                                 input logic [31:0] wd, input bit hold);
        bit          e    = exp_err(we, t, a);
        int          sz   = acc_size(t);
        int          aoff = int'(a[1:0]);
        bit          spl  = !e && (aoff + sz > 4);
        int          exp_lat, exp_n;
        logic [31:0] exp_rd;
        logic [3:0]  ebe [2];
        logic [31:0] ewd [2];
        logic [31:0] msk;
        exp_rd  = (!we && !e) ? model_load(t, a) : 32'h0;
        exp_lat = e ? 1 : (we ? (spl ? 3 : 2) : (spl ? 5 : 3));
        exp_n   = e ? 0 : (spl ? 2 : 1);
        ebe[0] = '0; ebe[1] = '0; ewd[0] = '0; ewd[1] = '0;
        for (int i = 0; i < sz; i++) begin
            int b = aoff + i;
            ebe[b/4][b%4] = 1'b1;
            ewd[b/4][8*(b%4) +: 8] = wd[8*i +: 8];
        end
        do_req(we, t, a, wd, hold);
        check("latency", last_lat, exp_lat);
        check("rsp_err", last_err, e);
        check("rsp_rdata", last_rdata, exp_rd);
        check("strobe_count", n_stb, exp_n);
        if (n_stb == exp_n) begin
            for (int k = 0; k < exp_n; k++) begin
                check("stb_we", stb_we[k], we);
                check("stb_addr", stb_addr[k], (base_idx(a)/4 + k) % DEPTH);
                if (we) begin
                    check("stb_be", stb_be[k], ebe[k]);
                    for (int l = 0; l < 4; l++) msk[8*l +: 8] = {8{ebe[k][l]}};
                    check("stb_wdata", stb_wd[k] & msk, ewd[k]);
                end
            end
        end
        if (we && !e)
            for (int i = 0; i < sz; i++) ref_mem[(base_idx(a) + i) % NBYTES] = wd[8*i +: 8];
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses, strobes;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = '0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_mem_en", mem_en, 0);
        check("reset_mem_we", mem_we, 0);
        check("reset_mem_be", mem_be, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        reset = 1'b0;

        // Word store / load round trip.
        run_and_check(1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
        check("sw_addr", stb_addr[0], 4);
        check("sw_be", stb_be[0], 4'b1111);
        check("sw_latency", last_lat, 2);
        run_and_check(0, 3'b010, 32'h10, 32'h0, 0);
        check("lw_data", last_rdata, 32'hDEADBEEF);
        check("lw_latency", last_lat, 3);

        // Byte lanes and sign/zero extension.
        run_and_check(1, 3'b000, 32'h13, 32'h00000080, 0);
        check("sb_be", stb_be[0], 4'b1000);
        check("sb_wdata", stb_wd[0], 32'h80808080);
        run_and_check(0, 3'b000, 32'h13, 32'h0, 0);
        check("lb_data", last_rdata, 32'hFFFFFF80);
        run_and_check(0, 3'b100, 32'h13, 32'h0, 0);
        check("lbu_data", last_rdata, 32'h00000080);

        // Halfword lanes and extension.
        run_and_check(1, 3'b001, 32'h12, 32'h00001234, 0);
        check("sh_be", stb_be[0], 4'b1100);
        run_and_check(0, 3'b001, 32'h12, 32'h0, 0);
        check("lh_pos", last_rdata, 32'h00001234);
        run_and_check(1, 3'b001, 32'h12, 32'h00008001, 0);
        run_and_check(0, 3'b001, 32'h12, 32'h0, 0);
        check("lh_neg", last_rdata, 32'hFFFF8001);
        run_and_check(0, 3'b101, 32'h12, 32'h0, 0);
        check("lhu_data", last_rdata, 32'h00008001);

        // Illegal func3 always errors without touching the RAM.
        run_and_check(0, 3'b011, 32'h10, 32'h0, 0);
        check("illegal_err", last_err, 1);
        check("illegal_latency", last_lat, 1);
        check("illegal_strobes", n_stb, 0);

`ifdef LSU_MISALIGN_SPLIT_EN
        run_and_check(1, 3'b010, 32'h10, 32'h11223344, 0);
        run_and_check(1, 3'b010, 32'h14, 32'h55667788, 0);
        run_and_check(0, 3'b010, 32'h11, 32'h0, 0);
        check("split_lw_data", last_rdata, 32'h88112233);
        check("split_lw_err", last_err, 0);
        check("split_lw_addr0", stb_addr[0], 4);
        check("split_lw_addr1", stb_addr[1], 5);
        run_and_check(1, 3'b010, NBYTES - 2, 32'hAABBCCDD, 0);
        check("wrap_addr0", stb_addr[0], DEPTH - 1);
        check("wrap_be0", stb_be[0], 4'b1100);
        check("wrap_addr1", stb_addr[1], 0);
        check("wrap_be1", stb_be[1], 4'b0011);
        run_and_check(0, 3'b010, NBYTES - 2, 32'h0, 0);
        check("wrap_lw_data", last_rdata, 32'hAABBCCDD);
`else
        run_and_check(0, 3'b010, 32'h11, 32'h0, 0);
        check("misal_err", last_err, 1);
        check("misal_rdata", last_rdata, 0);
        check("misal_strobes", n_stb, 0);
        check("misal_latency", last_lat, 1);
`endif

        // Fields churning under a held req_valid must not disturb the access.
        run_and_check(1, 3'b010, 32'h20, 32'hCAFEF00D, 1);
        run_and_check(0, 3'b010, 32'h20, 32'h0, 0);
        check("hold_readback", last_rdata, 32'hCAFEF00D);

        // Reset in the issue cycle of a load aborts it.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_type = 3'b010; req_addr = 32'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_mem_en", mem_en, 0);
        check("abort_req_ready", req_ready, 1);
        pulses = 0; strobes = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
            if (mem_en) strobes++;
        end
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
            if (mem_en) strobes++;
        end
        check("abort_no_rsp", pulses, 0);
        check("abort_no_strobe", strobes, 0);
        check("abort_ready_after", req_ready, 1);

        // Randomized traffic, biased to a small window and the top of memory.
        for (int n = 0; n < 400; n++) begin
            bit          we   = 1'($urandom_range(0, 1));
            logic [2:0]  t    = 3'($urandom_range(0, 7));
            int          sel  = $urandom_range(0, 3);
            logic [31:0] a    = $urandom & 32'hFFFF_FC00;
            bit          hold = ($urandom_range(0, 7) == 0);
            if (sel == 1) a = a | 32'h3F0 | 32'($urandom_range(0, 15));
            else          a = a | 32'($urandom_range(0, 47));
            run_and_check(we, t, a, $urandom, hold);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit that carries out the memory side of the decoder's S-type (SB/SH/SW) and L-type (LB/LH/LW/LBU/LHU) encodings. It takes a request (write enable, func3-coded access type, byte address, store data) and drives a 32-bit word-wide synchronous data RAM. The RAM has byte enables and 1-cycle read latency. The block returns aligned, sign- or zero-extended load data to the writeback mux through a valid/ready request handshake and a single-cycle response strobe.

Parameters:
MEM_AW, 8, word-address width of the data RAM (depth 2**MEM_AW words)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_type  in  3  func3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address; bits [MEM_AW+1:0] used
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle completion strobe
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  qualified by rsp_valid: misaligned or illegal type
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write
mem_be  out  4  byte-lane enables (bit i = bits [8i+7:8i])
mem_addr  out  MEM_AW  RAM word address
mem_wdata  out  32  lane-positioned write data
mem_rdata  in  32  RAM read data, valid the cycle after a read strobe

Behaviour:
- Reset values: all outputs 0, except req_ready = 1. State is IDLE.
- Reset asserted mid-operation aborts the request: no response is issued, and no RAM strobe occurs after reset asserts.
- Handshake: a request is accepted at the rising edge where req_valid && req_ready. All request fields are registered at that edge and the inputs are then ignored.
- FSM (single access): IDLE -> ISSUE -> (load: WAIT) -> DONE -> IDLE.
- ISSUE: mem_en = 1, mem_we = stored we, mem_addr = addr[MEM_AW+1:2].
- WAIT: mem_rdata is captured, lane-extracted and extended into rsp_rdata.
- DONE: rsp_valid = 1 for exactly one cycle; rsp_rdata and rsp_err are held only while rsp_valid is high (0 otherwise).
- Latency from the accept edge T: store rsp_valid in cycle T+2; load in T+3. Back-to-back throughput is one request per 3 (store) or 4 (load) cycles.
- Store lanes, where o = addr[1:0]:
  - SB: be = 0001 << o, wdata = {4{wdata[7:0]}}.
  - SH: be = 0011 << o, wdata = {2{wdata[15:0]}}.
  - SW: be = 1111.
- Load extraction, where o = addr[1:0]:
  - LB/LBU take byte o; LB sign-extends from bit 7, LBU zero-fills.
  - LH/LHU take bytes o..o+1; LH sign-extends from bit 15, LHU zero-fills.
  - LW takes all 4 bytes.
- Illegal type (load func3 011/110/111; store func3 not in 000/001/010): IDLE -> DONE with no RAM strobe, rsp_err = 1, rsp_rdata = 0.
- Alignment rule without the feature: H requires o[0] = 0 and W requires o = 00. A violation takes IDLE -> DONE with no RAM strobe, rsp_err = 1, rsp_rdata = 0.
- Address bits above MEM_AW+1 are ignored (memory aliases).
- mem_en is never high in IDLE or DONE.

Optional Feature:
Macro LSU_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned H/W accesses that stay within one word (e.g. H at o = 1) complete as a single access with shifted lanes.
  - Accesses that cross a word boundary (H at o = 3; W at o = 1..3) are split into two RAM accesses. The first is word w with the upper lanes (be = 1111 << o, masked to 4 bits). The second is word w+1 (wrapping modulo 2**MEM_AW) with the remaining low lanes.
  - Split FSM: IDLE -> ISSUE -> WAIT -> ISSUE2 -> WAIT2 -> DONE for loads; IDLE -> ISSUE -> ISSUE2 -> DONE for stores. Loads therefore add 2 cycles and stores add 1.
  - Load bytes are concatenated little-endian before extension.
  - rsp_err is raised only for illegal type.
- Undefined: any H/W misalignment gives rsp_err = 1 as described in Behaviour.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> store strobe mem_addr = 4, be = 1111 at T+1, rsp_valid at T+2; load rsp_rdata = 0xDEADBEEF at T+3 with rsp_err = 0.
- SB 0x80 @0x13, then LB and LBU @0x13 -> be = 1000, mem_wdata = 0x80808080; LB returns 0xFFFFFF80, LBU returns 0x00000080.
- SH 0x1234 @0x12, then LH @0x12 and LHU of 0x8001 @0x12 -> SH gives be = 1100; LH returns 0x00001234; after writing 0x8001, LH gives 0xFFFF8001 and LHU gives 0x00008001.
- LW @0x11 and load func3 = 011 -> without macro both give rsp_err = 1, rsp_rdata = 0, mem_en never asserted, rsp_valid at T+1. With macro, LW @0x11 over words 0x11223344 @4 and 0x55667788 @5 returns 0x88112233, err = 0, with two reads (addr 4 then 5).
- Wrap (macro only): SW 0xAABBCCDD at byte address 4*(2**MEM_AW)-2 -> first write word 2**MEM_AW-1 with be = 1100, then word 0 with be = 0011.
- Reset at T+1 of a load, plus a hold check -> rsp_valid never pulses, mem_en = 0 from the reset edge, req_ready = 1 after reset. Separately, req_valid held with changing fields while busy -> only the first request executes.
